// File: rtl/main_memory_responder_if.sv
// ---------------------------------------------------------------------------
// main_memory_responder_if
// Request/response bundle between the cache controller and the main-memory
// responder.
//   mem_read   : block-read request (read miss)
//   mem_write  : word-write request (write-through)
//   addr       : word address of the request
//   write_data : word to store on a write
//   read_block : returned cache line, offset n in bits [WIDTH*n +: WIDTH]
//   ready      : one-cycle completion pulse
//   busy       : request in flight
// master = cache controller side, slave = memory responder side.
// ---------------------------------------------------------------------------
interface main_memory_responder_if #(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int WORDS_IN_BLOCK = 4
);
  logic                              mem_read;
  logic                              mem_write;
  logic [ADDR_WIDTH-1:0]             addr;
  logic [WIDTH-1:0]                  write_data;
  logic [WIDTH*WORDS_IN_BLOCK-1:0]   read_block;
  logic                              ready;
  logic                              busy;

  modport master (
    output mem_read, mem_write, addr, write_data,
    input  read_block, ready, busy
  );

  modport slave (
    input  mem_read, mem_write, addr, write_data,
    output read_block, ready, busy
  );
endinterface

// File: rtl/main_memory_responder.sv
// ---------------------------------------------------------------------------
// main_memory_responder
// Slow backing store behind the direct-mapped cache. Serves one request at a
// time: a block read returns a whole line, a write stores one word. Every
// request completes LATENCY edges after acceptance with a one-cycle ready.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset (clears state and the whole array)
//   bus   : slave side of main_memory_responder_if (request in, line/ready/
//           busy out; all outputs registered)
// ---------------------------------------------------------------------------
module main_memory_responder #(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int WORDS_IN_BLOCK = 4,
  parameter int LATENCY        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  main_memory_responder_if.slave   bus
);

  localparam int          LP_DEPTH    = 2 ** ADDR_WIDTH;
  localparam int          LP_OFS_W    = $clog2(WORDS_IN_BLOCK);
  localparam int          LP_LINE_W   = WIDTH * WORDS_IN_BLOCK;
  localparam logic [3:0]  LP_CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [WIDTH-1:0]       r_wdata;
  logic [LP_LINE_W-1:0]   r_read_block;
  logic                   r_ready;
  logic                   r_busy;
  logic [WIDTH-1:0]       r_mem [LP_DEPTH];

  state_t                 w_next_state;
  logic [3:0]             w_next_cnt;
  logic                   w_accept_rd;
  logic                   w_accept_wr;
  logic                   w_do_rd;
  logic                   w_do_wr;

  // Next-state, counter and strobe decode.
  // DONE accepts a new request exactly like IDLE so that a request sampled at
  // the edge ending DONE starts immediately (spacing of LATENCY+1 cycles).
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept_rd  = 1'b0;
    w_accept_wr  = 1'b0;
    w_do_rd      = 1'b0;
    w_do_wr      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.mem_write) begin
          // write wins over a simultaneous read; the read is dropped
          w_next_state = ST_WR_WAIT;
          w_next_cnt   = LP_CNT_LOAD;
          w_accept_wr  = 1'b1;
        end else if (bus.mem_read) begin
          w_next_state = ST_RD_WAIT;
          w_next_cnt   = LP_CNT_LOAD;
          w_accept_rd  = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_next_cnt = r_cnt - 4'd1;
        end else begin
          w_next_state = ST_DONE;
          w_do_rd      = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_next_cnt = r_cnt - 4'd1;
        end else begin
          w_next_state = ST_DONE;
          w_do_wr      = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // Control state, operand capture and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_read_block <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept_rd || w_accept_wr) begin
        r_addr <= bus.addr;
      end
      if (w_accept_wr) begin
        r_wdata <= bus.write_data;
      end
      r_ready <= w_do_rd | w_do_wr;
      r_busy  <= (w_next_state != ST_IDLE);
      if (w_do_rd) begin
        // line base ignores the offset bits; offset 0 lands in the low word
        for (int n = 0; n < WORDS_IN_BLOCK; n++) begin
          r_read_block[n*WIDTH +: WIDTH] <=
            r_mem[{r_addr[ADDR_WIDTH-1:LP_OFS_W], n[LP_OFS_W-1:0]}];
        end
      end
    end
  end

  // Storage array: cleared on reset, one word written at write completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LP_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_wr) begin
        r_mem[r_addr] <= r_wdata;
      end
    end
  end

  assign bus.read_block = r_read_block;
  assign bus.ready      = r_ready;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_main_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_main_memory_responder
// Directed bench for main_memory_responder: a LATENCY=4 instance for the
// functional sequence and a LATENCY=1 instance for back-to-back traffic.
// ---------------------------------------------------------------------------
module tb_main_memory_responder;

  localparam int LAT4 = 4;
  // busy covers the cycle after acceptance through the DONE cycle
  localparam int BUSY4 = LAT4 + 1;
  // ready is seen in cycle k = LATENCY+1 (k=1 is the cycle after acceptance)
  localparam int RDYK4 = LAT4 + 1;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  main_memory_responder_if #(.WIDTH(32), .ADDR_WIDTH(10), .WORDS_IN_BLOCK(4)) bus4 ();
  main_memory_responder_if #(.WIDTH(32), .ADDR_WIDTH(10), .WORDS_IN_BLOCK(4)) bus1 ();

  main_memory_responder #(.WIDTH(32), .ADDR_WIDTH(10), .WORDS_IN_BLOCK(4), .LATENCY(LAT4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  main_memory_responder #(.WIDTH(32), .ADDR_WIDTH(10), .WORDS_IN_BLOCK(4), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on the LATENCY=4 instance (called at a negedge, returns
  // at a negedge with the DUT idle). pulse_k>0 raises mem_read for one cycle
  // at cycle k to probe that requests are ignored while busy.
  task automatic run4(input logic rd, input logic wr, input logic [9:0] a,
                      input logic [31:0] d, input int pulse_k,
                      output int n_ready, output int ready_k, output int n_busy,
                      output logic [127:0] blk_at_ready);
    n_ready      = 0;
    ready_k      = 0;
    n_busy       = 0;
    blk_at_ready = '0;
    bus4.mem_read   = rd;
    bus4.mem_write  = wr;
    bus4.addr       = a;
    bus4.write_data = d;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus4.ready === 1'b1) begin
        n_ready++;
        ready_k      = k;
        blk_at_ready = bus4.read_block;
      end
      if (bus4.busy === 1'b1) n_busy++;
      bus4.mem_write = 1'b0;
      if (k == pulse_k) begin
        bus4.mem_read = 1'b1;
        bus4.addr     = 10'h3C0;
      end else begin
        bus4.mem_read = 1'b0;
      end
    end
  endtask

  int           nr;
  int           rk;
  int           nb;
  logic [127:0] blk;
  logic [127:0] blk_before;

  logic         l1_wr   [6];
  logic [9:0]   l1_addr [6];
  logic [31:0]  l1_data [6];
  logic [127:0] l1_exp  [6];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus4.mem_read = 1'b0; bus4.mem_write = 1'b0; bus4.addr = '0; bus4.write_data = '0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.addr = '0; bus1.write_data = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {127'd0, bus4.ready}, 128'd0);
    check("rst_busy", {127'd0, bus4.busy}, 128'd0);
    check("rst_block", bus4.read_block, 128'd0);
    check("rst_busy_l1", {127'd0, bus1.busy}, 128'd0);
    reset = 1'b1;
    @(negedge clk);

    // read from cleared memory
    run4(1'b1, 1'b0, 10'h014, 32'h0, 0, nr, rk, nb, blk);
    check("rd0_nready", 128'(nr), 128'd1);
    check("rd0_readyk", 128'(rk), 128'(RDYK4));
    check("rd0_nbusy", 128'(nb), 128'(BUSY4));
    check("rd0_block", blk, 128'd0);

    // write-through then refill of the same line
    run4(1'b0, 1'b1, 10'h015, 32'hDEADBEEF, 0, nr, rk, nb, blk);
    check("wr1_nready", 128'(nr), 128'd1);
    check("wr1_readyk", 128'(rk), 128'(RDYK4));
    check("wr1_nbusy", 128'(nb), 128'(BUSY4));
    check("wr1_block_hold", bus4.read_block, 128'd0);
    run4(1'b1, 1'b0, 10'h014, 32'h0, 0, nr, rk, nb, blk);
    check("rd1_block", blk, 128'h00000000_00000000_DEADBEEF_00000000);
    check("rd1_block_hold", bus4.read_block, 128'h00000000_00000000_DEADBEEF_00000000);

    // simultaneous read+write: write wins, single ready
    run4(1'b1, 1'b1, 10'h020, 32'h12345678, 0, nr, rk, nb, blk);
    check("both_nready", 128'(nr), 128'd1);
    check("both_block_hold", bus4.read_block, 128'h00000000_00000000_DEADBEEF_00000000);
    run4(1'b1, 1'b0, 10'h020, 32'h0, 0, nr, rk, nb, blk);
    check("both_rd_block", blk, 128'h00000000_00000000_00000000_12345678);

    // read pulse during WR_WAIT is ignored
    blk_before = bus4.read_block;
    run4(1'b0, 1'b1, 10'h022, 32'hCAFEF00D, 2, nr, rk, nb, blk);
    check("busyreq_nready", 128'(nr), 128'd1);
    check("busyreq_nbusy", 128'(nb), 128'(BUSY4));
    check("busyreq_block", bus4.read_block, blk_before);
    run4(1'b1, 1'b0, 10'h023, 32'h0, 0, nr, rk, nb, blk);
    check("offset_ignored", blk, 128'h00000000_CAFEF00D_00000000_12345678);

    // reset two cycles into a write
    bus4.mem_write  = 1'b1;
    bus4.addr       = 10'h3FF;
    bus4.write_data = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    bus4.mem_write = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midwr_busy_pre", {127'd0, bus4.busy}, {127'd0, 1'b1});
    #1;
    reset = 1'b0;
    #1;
    check("midwr_busy_rst", {127'd0, bus4.busy}, 128'd0);
    check("midwr_ready_rst", {127'd0, bus4.ready}, 128'd0);
    check("midwr_block_rst", bus4.read_block, 128'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run4(1'b1, 1'b0, 10'h3FC, 32'h0, 0, nr, rk, nb, blk);
    check("midwr_nready", 128'(nr), 128'd1);
    check("midwr_discarded", blk, 128'd0);
    // also confirms the earlier writes were cleared by reset
    run4(1'b1, 1'b0, 10'h020, 32'h0, 0, nr, rk, nb, blk);
    check("rst_clears_mem", blk, 128'd0);

    // top-of-array address
    run4(1'b0, 1'b1, 10'h3FF, 32'h0BADCAFE, 0, nr, rk, nb, blk);
    run4(1'b1, 1'b0, 10'h3FF, 32'h0, 0, nr, rk, nb, blk);
    check("wrap_block", blk, 128'h0BADCAFE_00000000_00000000_00000000);

    // LATENCY=1: alternating write/read, new request every 2 cycles
    l1_wr[0] = 1'b1; l1_addr[0] = 10'h100; l1_data[0] = 32'h11111111; l1_exp[0] = 128'd0;
    l1_wr[1] = 1'b0; l1_addr[1] = 10'h100; l1_data[1] = 32'h0;
    l1_exp[1] = 128'h00000000_00000000_00000000_11111111;
    l1_wr[2] = 1'b1; l1_addr[2] = 10'h105; l1_data[2] = 32'h22222222; l1_exp[2] = 128'd0;
    l1_wr[3] = 1'b0; l1_addr[3] = 10'h104; l1_data[3] = 32'h0;
    l1_exp[3] = 128'h00000000_00000000_22222222_00000000;
    l1_wr[4] = 1'b1; l1_addr[4] = 10'h10A; l1_data[4] = 32'h33333333; l1_exp[4] = 128'd0;
    l1_wr[5] = 1'b0; l1_addr[5] = 10'h108; l1_data[5] = 32'h0;
    l1_exp[5] = 128'h00000000_33333333_00000000_00000000;
    for (int i = 0; i < 6; i++) begin
      bus1.mem_write  = l1_wr[i];
      bus1.mem_read   = ~l1_wr[i];
      bus1.addr       = l1_addr[i];
      bus1.write_data = l1_data[i];
      @(posedge clk);
      @(negedge clk);
      check($sformatf("l1_wait_ready_%0d", i), {127'd0, bus1.ready}, 128'd0);
      check($sformatf("l1_wait_busy_%0d", i), {127'd0, bus1.busy}, {127'd0, 1'b1});
      @(posedge clk);
      @(negedge clk);
      check($sformatf("l1_done_ready_%0d", i), {127'd0, bus1.ready}, {127'd0, 1'b1});
      if (!l1_wr[i]) begin
        check($sformatf("l1_block_%0d", i), bus1.read_block, l1_exp[i]);
      end
    end
    bus1.mem_read  = 1'b0;
    bus1.mem_write = 1'b0;
    @(negedge clk);
    check("l1_idle_ready", {127'd0, bus1.ready}, 128'd0);
    check("l1_idle_busy", {127'd0, bus1.busy}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
